// File: rtl/uart_reg_responder.sv
// Device-side register-access command responder sitting between a UART rx/tx pair and a register bus.
// Optional build macro UART_RESP_CHK_EN: checksummed writes and two-byte (data, addr^data) read responses.
module uart_reg_responder #(
  parameter int unsigned AW          = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic          sysclk,
  input  logic          reset_n,
  input  logic          rx_end_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_err_i,
  output logic          tx_start_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_end_i,
  output logic          reg_wr_o,
  output logic          reg_rd_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [7:0]    reg_wdata_o,
  input  logic [7:0]    reg_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  OP_WR = 8'h57;
  localparam logic [7:0]  OP_RD = 8'h52;
  localparam logic [7:0]  ACK   = 8'h06;
  localparam logic [7:0]  NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_RESP_CHK_EN
    GET_CHK,
`endif
    EXEC,
    WAIT_RD,
    SEND,
    WAIT_TX
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_wr_q, op_wr_d;
  logic [AW-1:0]   addr_d;
  logic [7:0]      wdata_d;
  logic [7:0]      txd_d;
  logic            tx_start_d, reg_wr_d, reg_rd_d, busy_d;
  logic            addr_ok, expired;
`ifdef UART_RESP_CHK_EN
  logic            pend_q, pend_d;
`endif

  // Next-state and next-output logic; every registered output is computed here as *_d.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    op_wr_d = op_wr_q;
    addr_d  = reg_addr_o;
    wdata_d = reg_wdata_o;
    txd_d   = tx_data_o;
`ifdef UART_RESP_CHK_EN
    pend_d  = pend_q;
`endif
    addr_ok = ((rx_data_i >> AW) == 8'd0);
    expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

    case (state_q)
      IDLE: begin
        if (rx_err_i) begin
          state_d = SEND;
          txd_d   = NAK;
        end else if (rx_end_i) begin
          if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
            state_d = GET_ADDR;
            op_wr_d = (rx_data_i == OP_WR);
          end else begin
            state_d = SEND;
            txd_d   = NAK;
          end
        end
      end
      GET_ADDR: begin
        if (rx_err_i || (rx_end_i && !addr_ok)) begin
          state_d = SEND;
          txd_d   = NAK;
        end else if (rx_end_i) begin
          addr_d  = AW'(rx_data_i);
          state_d = op_wr_q ? GET_DATA : EXEC;
        end else if (expired) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GET_DATA: begin
        if (rx_err_i) begin
          state_d = SEND;
          txd_d   = NAK;
        end else if (rx_end_i) begin
          wdata_d = rx_data_i;
`ifdef UART_RESP_CHK_EN
          state_d = GET_CHK;
`else
          state_d = EXEC;
`endif
        end else if (expired) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RESP_CHK_EN
      GET_CHK: begin
        if (rx_err_i || (rx_end_i && rx_data_i != (OP_WR ^ 8'(reg_addr_o) ^ reg_wdata_o))) begin
          state_d = SEND;
          txd_d   = NAK;
        end else if (rx_end_i) begin
          state_d = EXEC;
        end else if (expired) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      EXEC: begin
        if (op_wr_q) begin
          state_d = SEND;
          txd_d   = ACK;
        end else begin
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        txd_d   = reg_rdata_i;
        state_d = SEND;
`ifdef UART_RESP_CHK_EN
        pend_d  = 1'b1;
`endif
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_end_i) begin
`ifdef UART_RESP_CHK_EN
          // Second read-response byte follows immediately; tx_data_o still holds the read data.
          if (pend_q) begin
            state_d = SEND;
            txd_d   = tx_data_o ^ 8'(reg_addr_o);
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    tx_start_d = (state_d == SEND);
    reg_wr_d   = (state_d == EXEC) && op_wr_q;
    reg_rd_d   = (state_d == EXEC) && !op_wr_q;
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      tx_start_o  <= 1'b0;
      tx_data_o   <= '0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      busy_o      <= 1'b0;
`ifdef UART_RESP_CHK_EN
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      tx_start_o  <= tx_start_d;
      tx_data_o   <= txd_d;
      reg_wr_o    <= reg_wr_d;
      reg_rd_o    <= reg_rd_d;
      reg_addr_o  <= addr_d;
      reg_wdata_o <= wdata_d;
      busy_o      <= busy_d;
`ifdef UART_RESP_CHK_EN
      pend_q      <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Bench for uart_reg_responder: directed protocol cases plus randomized commands checked against a
// byte-level protocol model; honours UART_RESP_CHK_EN the same way the design does.
module tb_uart_reg_responder;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 40;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  logic          sysclk = 1'b0;
  logic          reset_n = 1'b1;
  logic          rx_end_i = 1'b0;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_err_i = 1'b0;
  logic          tx_start_o;
  logic [7:0]    tx_data_o;
  logic          tx_end_i = 1'b0;
  logic          reg_wr_o;
  logic          reg_rd_o;
  logic [AW-1:0] reg_addr_o;
  logic [7:0]    reg_wdata_o;
  logic [7:0]    reg_rdata_i = 8'h00;
  logic          busy_o;

  always #5 sysclk = ~sysclk;

  uart_reg_responder #(.AW(AW), .TIMEOUT_CYC(TO)) dut (
    .sysclk(sysclk), .reset_n(reset_n),
    .rx_end_i(rx_end_i), .rx_data_i(rx_data_i), .rx_err_i(rx_err_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_end_i(tx_end_i),
    .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;
  int t_now = 0;
  int rd_data_t = -1;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0] model_mem [16];
  logic [7:0] bus_mem [16];
  logic [9:0] cmd [8];
  int cmd_len = 0;

  int o_nwr, o_nrd, o_both, o_ntx, o_wr_t, o_rd_t;
  logic [AW-1:0] o_wa, o_ra;
  logic [7:0] o_wd;
  int o_tx_t [4];
  logic [7:0] o_txb [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and play the register-bus side.
  task automatic next_cycle();
    @(negedge sysclk);
    t_now++;
    if (reset_n && reg_wr_o) bus_mem[reg_addr_o] = reg_wdata_o;
    if (reset_n && reg_rd_o) begin
      rd_data_t = t_now + 1;
      rd_addr   = reg_addr_o;
    end
  endtask

  // Read data is valid only in the cycle after the strobe; junk otherwise.
  task automatic drive(input logic e, input logic [7:0] d, input logic er, input logic te);
    rx_end_i    = e;
    rx_data_i   = d;
    rx_err_i    = er;
    tx_end_i    = te;
    reg_rdata_i = (t_now == rd_data_t) ? bus_mem[rd_addr] : 8'($urandom);
  endtask

  task automatic observe();
    if (reg_wr_o) begin o_nwr++; o_wr_t = t_now; o_wa = reg_addr_o; o_wd = reg_wdata_o; end
    if (reg_rd_o) begin o_nrd++; o_rd_t = t_now; o_ra = reg_addr_o; end
    if (reg_wr_o && reg_rd_o) o_both++;
    if (tx_start_o) begin
      if (o_ntx < 4) begin o_tx_t[o_ntx] = t_now; o_txb[o_ntx] = tx_data_o; end
      o_ntx++;
    end
  endtask

  task automatic add(input logic e, input logic er, input logic [7:0] d);
    cmd[cmd_len] = {e, er, d};
    cmd_len++;
  endtask

  // Protocol model: walks the byte list and decides the outcome and which item ends the command.
  task automatic predict(output int term, output int lat, output bit ewr, output bit erd,
                         output logic [AW-1:0] ea, output logic [7:0] ed, output int nexp,
                         output logic [7:0] r0, output logic [7:0] r1);
    int pos;
    logic [7:0] op, addr, data, b;
    pos = 0; op = 0; addr = 0; data = 0;
    term = -1; lat = 0; ewr = 0; erd = 0; ea = '0; ed = 0; nexp = 0; r0 = 0; r1 = 0;
    for (int i = 0; i < cmd_len; i++) begin
      if (term < 0) begin
        b = cmd[i][7:0];
        if (cmd[i][8]) begin
          term = i; lat = 1; nexp = 1; r0 = NAK;
        end else if (cmd[i][9]) begin
          if (pos == 0) begin
            if (b == OP_W || b == OP_R) op = b;
            else begin term = i; lat = 1; nexp = 1; r0 = NAK; end
          end else if (pos == 1) begin
            if (int'(b) >= (1 << AW)) begin
              term = i; lat = 1; nexp = 1; r0 = NAK;
            end else begin
              addr = b;
              if (op == OP_R) begin
                term = i; lat = 3; erd = 1; ea = AW'(addr); nexp = 1;
                r0 = model_mem[addr[AW-1:0]];
`ifdef UART_RESP_CHK_EN
                nexp = 2; r1 = addr ^ r0;
`endif
              end
            end
          end else if (pos == 2) begin
            data = b;
`ifndef UART_RESP_CHK_EN
            term = i; lat = 2; ewr = 1; ea = AW'(addr); ed = data; nexp = 1; r0 = ACK;
`endif
          end else begin
            if (b == (OP_W ^ addr ^ data)) begin
              term = i; lat = 2; ewr = 1; ea = AW'(addr); ed = data; nexp = 1; r0 = ACK;
            end else begin
              term = i; lat = 1; nexp = 1; r0 = NAK;
            end
          end
          pos++;
        end
      end
    end
  endtask

  // Send cmd[] with gap idle cycles between items, act as the transmitter, then compare.
  task automatic exec_cmd(input int gap, input int txdly, input bit inject);
    int term, lat, nexp, L, start_t, end_at, last_end, first_end, served, budget;
    bit ewr, erd;
    logic [AW-1:0] ea;
    logic [7:0] ed, r0, r1, cur;
    predict(term, lat, ewr, erd, ea, ed, nexp, r0, r1);
    o_nwr = 0; o_nrd = 0; o_both = 0; o_ntx = 0; o_wr_t = -1; o_rd_t = -1;
    L = t_now; cur = 0;
    for (int i = 0; i <= term; i++) begin
      for (int g = 0; g < ((i == 0) ? 0 : gap); g++) begin
        next_cycle(); observe(); drive(1'b0, 8'h00, 1'b0, 1'b0);
      end
      next_cycle(); observe(); drive(cmd[i][9], cmd[i][7:0], cmd[i][8], 1'b0);
      L = t_now;
    end
    start_t = -10; end_at = -1; last_end = -1; first_end = -1; served = 0;
    budget = t_now + 40 + 4 * txdly;
    while ((t_now < budget) && !((served >= nexp) && (t_now >= last_end + 3))) begin
      next_cycle(); observe();
      if (t_now == L + 1) check("busy_high", 32'(busy_o), 32'd1);
      if ((served == nexp) && (t_now == last_end + 1)) check("busy_fall", 32'(busy_o), 32'd0);
      if (tx_start_o) begin
        cur = tx_data_o; start_t = t_now; end_at = t_now + txdly;
      end else if (end_at >= 0) begin
        check("tx_hold", 32'(tx_data_o), 32'(cur));
      end
      if (t_now == end_at) begin
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        served++; last_end = t_now; end_at = -1;
        if (first_end < 0) first_end = t_now;
      end else if (inject && (t_now == start_t + 1) && (end_at > t_now)) begin
        drive(1'b1, 8'h41, 1'b0, 1'b0);
      end else begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
      end
    end
    check("resp_served", 32'(served), 32'(nexp));
    check("wr_count", 32'(o_nwr), 32'(ewr));
    if (ewr) begin
      check("wr_lat", 32'(o_wr_t), 32'(L + 1));
      check("wr_addr", 32'(o_wa), 32'(ea));
      check("wr_data", 32'(o_wd), 32'(ed));
      model_mem[ea] = ed;
    end
    check("rd_count", 32'(o_nrd), 32'(erd));
    if (erd) begin
      check("rd_lat", 32'(o_rd_t), 32'(L + 1));
      check("rd_addr", 32'(o_ra), 32'(ea));
    end
    check("strobe_overlap", 32'(o_both), 32'd0);
    check("tx_count", 32'(o_ntx), 32'(nexp));
    if (o_ntx >= 1) begin
      check("tx_lat", 32'(o_tx_t[0]), 32'(L + lat));
      check("tx_byte0", 32'(o_txb[0]), 32'(r0));
    end
    if ((nexp == 2) && (o_ntx >= 2)) begin
      check("tx2_lat", 32'(o_tx_t[1]), 32'(first_end + 1));
      check("tx_byte1", 32'(o_txb[1]), 32'(r1));
    end
  endtask

  // Partial write then silence: expect a silent return to idle exactly TO cycles after the last byte.
  task automatic timeout_test(input logic [7:0] a);
    next_cycle(); drive(1'b1, OP_W, 1'b0, 1'b0);
    next_cycle(); drive(1'b1, a, 1'b0, 1'b0);
    o_nwr = 0; o_nrd = 0; o_both = 0; o_ntx = 0;
    for (int j = 1; j <= int'(TO) + 3; j++) begin
      next_cycle(); observe();
      if (j == int'(TO)) check("to_busy_before", 32'(busy_o), 32'd1);
      if (j == int'(TO) + 1) check("to_busy_after", 32'(busy_o), 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("to_no_tx", 32'(o_ntx), 32'd0);
    check("to_no_wr", 32'(o_nwr), 32'd0);
  endtask

  // Read, then assert reset while the response is in flight.
  task automatic reset_test();
    bit seen;
    next_cycle(); drive(1'b1, OP_R, 1'b0, 1'b0);
    next_cycle(); drive(1'b1, 8'h05, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      next_cycle();
      if (tx_start_o) seen = 1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("rst_tx_seen", 32'(seen), 32'd1);
    next_cycle(); drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_pre_busy", 32'(busy_o), 32'd1);
    check("rst_pre_addr", 32'(reg_addr_o), 32'd5);
    #1 reset_n = 1'b0;
    #1;
    check("rst_tx_start", 32'(tx_start_o), 32'd0);
    check("rst_tx_data", 32'(tx_data_o), 32'd0);
    check("rst_addr", 32'(reg_addr_o), 32'd0);
    check("rst_wdata", 32'(reg_wdata_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    next_cycle(); next_cycle();
    reset_n = 1'b1;
    next_cycle(); drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_idle_busy", 32'(busy_o), 32'd0);
    check("rst_idle_tx", 32'(tx_start_o), 32'd0);
  endtask

  initial begin
    logic [7:0] a, d;
    int kind;
    for (int i = 0; i < 16; i++) begin model_mem[i] = 8'h00; bus_mem[i] = 8'h00; end
    reset_n = 1'b0;
    #2;
    check("init_tx_start", 32'(tx_start_o), 32'd0);
    check("init_tx_data", 32'(tx_data_o), 32'd0);
    check("init_wr", 32'(reg_wr_o), 32'd0);
    check("init_rd", 32'(reg_rd_o), 32'd0);
    check("init_addr", 32'(reg_addr_o), 32'd0);
    check("init_wdata", 32'(reg_wdata_o), 32'd0);
    check("init_busy", 32'(busy_o), 32'd0);
    @(negedge sysclk); @(negedge sysclk);
    reset_n = 1'b1;
    next_cycle(); drive(1'b0, 8'h00, 1'b0, 1'b0);

    cmd_len = 0; add(1, 0, OP_W); add(1, 0, 8'h03); add(1, 0, 8'hA5);
`ifdef UART_RESP_CHK_EN
    add(1, 0, OP_W ^ 8'h03 ^ 8'hA5);
`endif
    exec_cmd(0, 2, 0);
    cmd_len = 0; add(1, 0, OP_R); add(1, 0, 8'h03); exec_cmd(1, 3, 0);
    cmd_len = 0; add(1, 0, 8'h41); exec_cmd(0, 2, 1);
    cmd_len = 0; add(1, 0, OP_R); add(1, 0, 8'h10); exec_cmd(0, 1, 0);

    timeout_test(8'h02);
    cmd_len = 0; add(1, 0, OP_R); add(1, 0, 8'h02); exec_cmd(0, 1, 0);
    cmd_len = 0; add(1, 0, OP_R); add(1, 0, 8'h03); exec_cmd(int'(TO) - 1, 1, 0);

    cmd_len = 0; add(1, 0, OP_W); add(0, 1, 8'h00); exec_cmd(0, 2, 0);
    cmd_len = 0; add(1, 0, OP_R); add(1, 1, 8'h03); exec_cmd(0, 2, 0);
    cmd_len = 0; add(1, 0, OP_R); add(1, 0, 8'h03); exec_cmd(0, 4, 1);

`ifdef UART_RESP_CHK_EN
    cmd_len = 0; add(1, 0, OP_W); add(1, 0, 8'h01); add(1, 0, 8'h10); add(1, 0, 8'h46); exec_cmd(0, 2, 0);
    cmd_len = 0; add(1, 0, OP_W); add(1, 0, 8'h01); add(1, 0, 8'h22); add(1, 0, 8'h00); exec_cmd(0, 2, 0);
    cmd_len = 0; add(1, 0, OP_R); add(1, 0, 8'h01); exec_cmd(0, 3, 0);
`endif

    cmd_len = 0; add(1, 0, OP_W); add(1, 0, 8'h05); add(1, 0, 8'hC3);
`ifdef UART_RESP_CHK_EN
    add(1, 0, OP_W ^ 8'h05 ^ 8'hC3);
`endif
    exec_cmd(0, 1, 0);
    reset_test();

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      cmd_len = 0;
      if (kind < 4) begin
        add(1, 0, OP_W); add(1, 0, a); add(1, 0, d);
`ifdef UART_RESP_CHK_EN
        add(1, 0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : (OP_W ^ a ^ d));
`endif
      end else if (kind < 8) begin
        add(1, 0, OP_R); add(1, 0, a);
      end else if (kind == 8) begin
        if (d == OP_W || d == OP_R) d = 8'h41;
        add(1, 0, d);
      end else begin
        add(1, 0, ($urandom_range(0, 1) == 0) ? OP_W : OP_R);
        if ($urandom_range(0, 1) == 0) add(0, 1, 8'h00);
        else add(1, 1, a);
      end
      exec_cmd(int'($urandom_range(0, 3)), int'($urandom_range(2, 4)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
